// File: rtl/prt_frame_reader_if.sv
// Signal bundle between the PRT drain engine and its neighbours: slot offer,
// PRT read port, invalidate, egress byte stream and status.
interface prt_frame_reader_if #(
   parameter int INDEX_SIZE = 3,
   parameter int DATA_SIZE  = 8,
   parameter int LEN_W      = 16
);
   logic                  slot_valid;
   logic [INDEX_SIZE-1:0] slot_id;
   logic [LEN_W-1:0]      slot_len;
   logic                  slot_ready;
   logic                  abort;
   logic                  rd_req;
   logic [INDEX_SIZE-1:0] rd_slot;
   logic [LEN_W-1:0]      rd_addr;
   logic [DATA_SIZE-1:0]  rd_data;
   logic                  inv_valid;
   logic [INDEX_SIZE-1:0] inv_slot;
   logic                  tx_valid;
   logic [DATA_SIZE-1:0]  tx_data;
   logic                  tx_last;
   logic                  tx_ready;
   logic                  busy;
   logic                  err_len;
   logic [LEN_W-1:0]      frames_sent;

   modport slave (
      input  slot_valid, slot_id, slot_len, abort, rd_data, tx_ready,
      output slot_ready, rd_req, rd_slot, rd_addr, inv_valid, inv_slot,
             tx_valid, tx_data, tx_last, busy, err_len, frames_sent
   );

   modport master (
      output slot_valid, slot_id, slot_len, abort, rd_data, tx_ready,
      input  slot_ready, rd_req, rd_slot, rd_addr, inv_valid, inv_slot,
             tx_valid, tx_data, tx_last, busy, err_len, frames_sent
   );
endinterface

// File: rtl/prt_frame_reader.sv
// PRT read-side drain engine: fetches a received frame slot byte by byte,
// streams it to the egress MAC through a small FIFO, then invalidates the slot.
module prt_frame_reader #(
   parameter int TABLE_SIZE = 8,
   parameter int INDEX_SIZE = 3,
   parameter int DATA_SIZE  = 8,
   parameter int LEN_W      = 16,
   parameter int FRAME_SIZE = 1518,
   parameter int FIFO_DEPTH = 4
) (
   input logic              clk,
   input logic              rst,
   prt_frame_reader_if.slave bus
);
   localparam logic [1:0] S_IDLE    = 2'd0;
   localparam logic [1:0] S_READ    = 2'd1;
   localparam logic [1:0] S_RELEASE = 2'd2;

   localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
   localparam logic [CNT_W:0]   DEPTH_V = (CNT_W + 1)'(FIFO_DEPTH);
   localparam logic [PTR_W-1:0] PTR_MAX = PTR_W'(FIFO_DEPTH - 1);

   if (TABLE_SIZE > (1 << INDEX_SIZE)) begin : g_cfg_check
      $error("INDEX_SIZE too narrow for TABLE_SIZE");
   end

   logic [1:0]            state;
   logic [INDEX_SIZE-1:0] slot_q;
   logic [LEN_W-1:0]      len_q;
   logic [LEN_W-1:0]      addr_q;
   logic [LEN_W-1:0]      frames_q;
   logic                  inflight_q;
   logic                  inflight_last_q;
   logic                  err_q;

   logic [DATA_SIZE:0]    fifo_mem [FIFO_DEPTH];
   logic [PTR_W-1:0]      wr_ptr;
   logic [PTR_W-1:0]      rd_ptr;
   logic [CNT_W-1:0]      count;

   logic                  in_read;
   logic                  accept;
   logic                  len_ok;
   logic                  rd_req;
   logic                  push;
   logic                  pop;
   logic                  tx_valid;
   logic                  last_hs;
   logic                  do_abort;
   logic [DATA_SIZE:0]    head;
   logic [CNT_W:0]        used;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_MAX) ? '0 : p + 1'b1;
   endfunction

   always_comb begin
      in_read  = (state == S_READ);
      accept   = bus.slot_valid && (state == S_IDLE);
      len_ok   = (bus.slot_len != '0) && (bus.slot_len <= LEN_W'(FRAME_SIZE));
      do_abort = in_read && bus.abort;
      // Credit counts the byte still in flight from the PRT so the FIFO cannot overflow.
      used     = (CNT_W + 1)'(count) + (CNT_W + 1)'(inflight_q);
      rd_req   = in_read && (addr_q < len_q) && (used < DEPTH_V);
      push     = inflight_q && in_read && !bus.abort;
      tx_valid = (count != '0);
      pop      = tx_valid && bus.tx_ready;
      head     = fifo_mem[rd_ptr];
      last_hs  = pop && head[DATA_SIZE];
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state           <= S_IDLE;
         slot_q          <= '0;
         len_q           <= '0;
         addr_q          <= '0;
         frames_q        <= '0;
         inflight_q      <= 1'b0;
         inflight_last_q <= 1'b0;
         err_q           <= 1'b0;
      end else begin
         err_q      <= accept && !len_ok;
         inflight_q <= rd_req && !bus.abort;
         if (rd_req) begin
            addr_q          <= addr_q + 1'b1;
            inflight_last_q <= (addr_q == len_q - 1'b1);
         end
         case (state)
            S_IDLE: begin
               if (accept) begin
                  slot_q <= bus.slot_id;
                  len_q  <= bus.slot_len;
                  addr_q <= '0;
                  state  <= len_ok ? S_READ : S_RELEASE;
               end
            end
            S_READ: begin
               // Abort takes priority over a coincident last-byte handshake.
               if (bus.abort) begin
                  state <= S_RELEASE;
               end else if (last_hs) begin
                  state    <= S_RELEASE;
                  frames_q <= frames_q + 1'b1;
               end
            end
            S_RELEASE: state <= S_IDLE;
            default:   state <= S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (do_abort) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= ptr_inc(wr_ptr);
         if (pop)  rd_ptr <= ptr_inc(rd_ptr);
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push) fifo_mem[wr_ptr] <= {inflight_last_q, bus.rd_data};
   end

   assign bus.slot_ready  = (state == S_IDLE);
   assign bus.busy        = (state != S_IDLE);
   assign bus.rd_req      = rd_req;
   assign bus.rd_slot     = slot_q;
   assign bus.rd_addr     = addr_q;
   assign bus.inv_valid   = (state == S_RELEASE);
   assign bus.inv_slot    = slot_q;
   assign bus.tx_valid    = tx_valid;
   assign bus.tx_data     = tx_valid ? head[DATA_SIZE-1:0] : '0;
   assign bus.tx_last     = tx_valid && head[DATA_SIZE];
   assign bus.err_len     = err_q;
   assign bus.frames_sent = frames_q;
endmodule

// File: tb/tb_prt_frame_reader.sv
// Directed self-checking bench for prt_frame_reader with a behavioural PRT model.
module tb_prt_frame_reader;
   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   prt_frame_reader_if #(.INDEX_SIZE(3), .DATA_SIZE(8), .LEN_W(16)) bus ();

   prt_frame_reader #(
      .TABLE_SIZE(8), .INDEX_SIZE(3), .DATA_SIZE(8),
      .LEN_W(16), .FRAME_SIZE(1518), .FIFO_DEPTH(4)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [7:0] prt_byte(input logic [2:0] s, input logic [15:0] a);
      return a[7:0] ^ {s, 5'b00000};
   endfunction

   // PRT read port: one-cycle latency
   always @(posedge clk) if (bus.rd_req) bus.rd_data <= prt_byte(bus.rd_slot, bus.rd_addr);

   logic [8:0] beats[$];
   int         beat_cyc[$];
   int acc_cyc, inv_cnt, inv_cyc, err_cnt, err_cyc, rdreq_cnt;
   int issued, popped, credit_viol, hold_viol, abort_cyc, last_valid_cyc;
   logic [2:0] inv_slot_seen;
   logic       prev_stall;
   logic [8:0] prev_head;

   always @(negedge clk) begin
      if (rst) begin
         if (bus.slot_valid && bus.slot_ready) acc_cyc = cyc;
         if (bus.rd_req) begin
            if (issued - popped >= 4) credit_viol++;
            issued++;
            rdreq_cnt++;
         end
         if (bus.tx_valid) last_valid_cyc = cyc;
         if (prev_stall && (!bus.tx_valid || {bus.tx_last, bus.tx_data} !== prev_head)) hold_viol++;
         prev_stall = bus.tx_valid && !bus.tx_ready;
         prev_head  = {bus.tx_last, bus.tx_data};
         if (bus.tx_valid && bus.tx_ready) begin
            beats.push_back({bus.tx_last, bus.tx_data});
            beat_cyc.push_back(cyc);
            popped++;
         end
         if (bus.inv_valid) begin
            inv_cnt++;
            inv_cyc = cyc;
            inv_slot_seen = bus.inv_slot;
         end
         if (bus.err_len) begin
            err_cnt++;
            err_cyc = cyc;
         end
         if (bus.abort && bus.busy) abort_cyc = cyc;
      end
   end

   task automatic clear_mon();
      beats.delete();
      beat_cyc.delete();
      acc_cyc = -100; inv_cnt = 0; inv_cyc = -100; err_cnt = 0; err_cyc = -100;
      rdreq_cnt = 0; issued = 0; popped = 0; credit_viol = 0; hold_viol = 0;
      abort_cyc = -1; last_valid_cyc = -1; inv_slot_seen = '0; prev_stall = 1'b0;
      prev_head = '0;
   endtask

   task automatic start_slot(input logic [2:0] id, input logic [15:0] len);
      int n = 0;
      while (!bus.slot_ready && n < 300) begin
         @(posedge clk); #1; n++;
      end
      checks++;
      if (!bus.slot_ready) begin
         errors++;
         $display("FAIL slot_ready_timeout: got 0 expected 1 (slot %0d)", id);
      end
      bus.slot_valid = 1'b1;
      bus.slot_id    = id;
      bus.slot_len   = len;
      @(posedge clk); #1;
      bus.slot_valid = 1'b0;
   endtask

   task automatic wait_done(input int target_inv, input bit toggle);
      int n = 0;
      while (n < 2000 && !(inv_cnt >= target_inv && bus.slot_ready)) begin
         @(posedge clk); #1;
         if (toggle) bus.tx_ready = ~bus.tx_ready;
         n++;
      end
      checks++;
      if (!(inv_cnt >= target_inv && bus.slot_ready)) begin
         errors++;
         $display("FAIL frame_done_timeout: got inv_cnt %0d expected %0d", inv_cnt, target_inv);
      end
   endtask

   task automatic test_reset();
      logic [6:0] flags;
      repeat (3) @(posedge clk);
      @(negedge clk);
      flags = {bus.slot_ready, bus.busy, bus.rd_req, bus.inv_valid, bus.tx_valid, bus.tx_last, bus.err_len};
      checks++;
      if (flags !== 7'b1000000) begin errors++; $display("FAIL reset_flags: got %b expected 1000000", flags); end
      checks++;
      if (bus.frames_sent !== 16'd0) begin errors++; $display("FAIL reset_frames: got %0d expected 0", bus.frames_sent); end
      checks++;
      if ({bus.tx_data, bus.rd_addr, bus.rd_slot, bus.inv_slot} !== 30'd0) begin
         errors++; $display("FAIL reset_buses: got %h expected 0", {bus.tx_data, bus.rd_addr, bus.rd_slot, bus.inv_slot});
      end
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_single_byte();
      clear_mon();
      bus.tx_ready = 1'b1;
      start_slot(3'd2, 16'd1);
      wait_done(1, 1'b0);
      checks++;
      if (beats.size() != 1) begin errors++; $display("FAIL single_count: got %0d expected 1", beats.size()); end
      else begin
         checks++;
         if (beats[0] !== 9'h140) begin errors++; $display("FAIL single_beat: got %h expected 140", beats[0]); end
         checks++;
         if (beat_cyc[0] - acc_cyc != 3) begin errors++; $display("FAIL single_latency: got %0d expected 3", beat_cyc[0] - acc_cyc); end
         checks++;
         if (inv_cyc != beat_cyc[0] + 1) begin errors++; $display("FAIL single_inv_time: got %0d expected %0d", inv_cyc, beat_cyc[0] + 1); end
      end
      checks++;
      if (inv_cnt != 1 || inv_slot_seen !== 3'd2) begin
         errors++; $display("FAIL single_inv: got cnt %0d slot %0d expected cnt 1 slot 2", inv_cnt, inv_slot_seen);
      end
      checks++;
      if (bus.frames_sent !== 16'd1) begin errors++; $display("FAIL single_frames: got %0d expected 1", bus.frames_sent); end
   endtask

   task automatic test_stream64();
      int bad_data = 0, bad_last = 0, bad_gap = 0;
      clear_mon();
      bus.tx_ready = 1'b1;
      start_slot(3'd0, 16'd64);
      wait_done(1, 1'b0);
      checks++;
      if (beats.size() != 64) begin errors++; $display("FAIL stream_count: got %0d expected 64", beats.size()); end
      else begin
         for (int i = 0; i < 64; i++) begin
            if (beats[i][7:0] !== 8'(i)) bad_data++;
            if (beats[i][8] !== (i == 63)) bad_last++;
            if (beat_cyc[i] != beat_cyc[0] + i) bad_gap++;
         end
         checks++;
         if (bad_data != 0) begin errors++; $display("FAIL stream_data: got %0d bad bytes expected 0", bad_data); end
         checks++;
         if (bad_last != 0) begin errors++; $display("FAIL stream_last: got %0d bad flags expected 0", bad_last); end
         checks++;
         if (bad_gap != 0) begin errors++; $display("FAIL stream_bubbles: got %0d gaps expected 0", bad_gap); end
         checks++;
         if (beat_cyc[0] - acc_cyc != 3) begin errors++; $display("FAIL stream_latency: got %0d expected 3", beat_cyc[0] - acc_cyc); end
      end
      checks++;
      if (bus.frames_sent !== 16'd2) begin errors++; $display("FAIL stream_frames: got %0d expected 2", bus.frames_sent); end
   endtask

   task automatic test_backpressure();
      int bad = 0;
      clear_mon();
      bus.tx_ready = 1'b1;
      start_slot(3'd1, 16'd16);
      wait_done(1, 1'b1);
      bus.tx_ready = 1'b1;
      checks++;
      if (beats.size() != 16) begin errors++; $display("FAIL stall_count: got %0d expected 16", beats.size()); end
      else begin
         for (int i = 0; i < 16; i++)
            if (beats[i] !== {(i == 15), prt_byte(3'd1, 16'(i))}) bad++;
         checks++;
         if (bad != 0) begin errors++; $display("FAIL stall_data: got %0d bad beats expected 0", bad); end
      end
      checks++;
      if (hold_viol != 0) begin errors++; $display("FAIL stall_hold: got %0d changes expected 0", hold_viol); end
      checks++;
      if (credit_viol != 0) begin errors++; $display("FAIL stall_credit: got %0d overruns expected 0", credit_viol); end
      checks++;
      if (bus.frames_sent !== 16'd3) begin errors++; $display("FAIL stall_frames: got %0d expected 3", bus.frames_sent); end
   endtask

   task automatic test_bad_len();
      clear_mon();
      start_slot(3'd4, 16'd0);
      wait_done(1, 1'b0);
      checks++;
      if (err_cyc != acc_cyc + 1) begin errors++; $display("FAIL len0_err_time: got %0d expected %0d", err_cyc, acc_cyc + 1); end
      start_slot(3'd5, 16'd1519);
      wait_done(2, 1'b0);
      checks++;
      if (err_cnt != 2) begin errors++; $display("FAIL badlen_err: got %0d expected 2", err_cnt); end
      checks++;
      if (rdreq_cnt != 0 || beats.size() != 0) begin
         errors++; $display("FAIL badlen_reads: got %0d reads %0d beats expected 0 0", rdreq_cnt, beats.size());
      end
      checks++;
      if (inv_cnt != 2 || inv_slot_seen !== 3'd5) begin
         errors++; $display("FAIL badlen_inv: got cnt %0d slot %0d expected cnt 2 slot 5", inv_cnt, inv_slot_seen);
      end
      checks++;
      if (bus.frames_sent !== 16'd3) begin errors++; $display("FAIL badlen_frames: got %0d expected 3", bus.frames_sent); end
   endtask

   task automatic test_abort();
      int n = 0, bad = 0, lasts = 0;
      clear_mon();
      bus.tx_ready = 1'b1;
      start_slot(3'd6, 16'd100);
      while (beats.size() < 11 && n < 300) begin
         @(posedge clk); #1; n++;
      end
      bus.abort = 1'b1;
      @(posedge clk); #1;
      bus.abort = 1'b0;
      wait_done(1, 1'b0);
      checks++;
      if (beats.size() < 11 || beats.size() > 12) begin
         errors++; $display("FAIL abort_count: got %0d expected 11..12", beats.size());
      end
      for (int i = 0; i < beats.size(); i++) begin
         if (beats[i][7:0] !== prt_byte(3'd6, 16'(i))) bad++;
         if (beats[i][8]) lasts++;
      end
      checks++;
      if (bad != 0) begin errors++; $display("FAIL abort_data: got %0d bad bytes expected 0", bad); end
      checks++;
      if (lasts != 0) begin errors++; $display("FAIL abort_last: got %0d expected 0", lasts); end
      checks++;
      if (abort_cyc < 0 || last_valid_cyc > abort_cyc) begin
         errors++; $display("FAIL abort_tx_valid: got last valid cycle %0d expected <= %0d", last_valid_cyc, abort_cyc);
      end
      checks++;
      if (inv_cnt != 1 || inv_slot_seen !== 3'd6) begin
         errors++; $display("FAIL abort_inv: got cnt %0d slot %0d expected cnt 1 slot 6", inv_cnt, inv_slot_seen);
      end
      checks++;
      if (bus.slot_ready !== 1'b1 || bus.tx_valid !== 1'b0) begin
         errors++; $display("FAIL abort_idle: got ready %b valid %b expected 1 0", bus.slot_ready, bus.tx_valid);
      end
      checks++;
      if (bus.frames_sent !== 16'd3) begin errors++; $display("FAIL abort_frames: got %0d expected 3", bus.frames_sent); end
   endtask

   task automatic test_back_to_back();
      int n = 0, bad = 0;
      logic [6:0] flags;
      clear_mon();
      bus.tx_ready = 1'b1;
      start_slot(3'd7, 16'd50);
      while (beats.size() < 5 && n < 300) begin
         @(posedge clk); #1; n++;
      end
      rst = 1'b0;
      #1;
      flags = {bus.slot_ready, bus.busy, bus.rd_req, bus.inv_valid, bus.tx_valid, bus.tx_last, bus.err_len};
      checks++;
      if (flags !== 7'b1000000) begin errors++; $display("FAIL midrst_flags: got %b expected 1000000", flags); end
      checks++;
      if ({bus.frames_sent, bus.tx_data, bus.rd_addr} !== 40'd0) begin
         errors++; $display("FAIL midrst_buses: got %h expected 0", {bus.frames_sent, bus.tx_data, bus.rd_addr});
      end
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b1;
      clear_mon();
      @(posedge clk); #1;
      start_slot(3'd3, 16'd8);
      start_slot(3'd5, 16'd8);
      wait_done(2, 1'b0);
      checks++;
      if (beats.size() != 16) begin errors++; $display("FAIL b2b_count: got %0d expected 16", beats.size()); end
      else begin
         for (int i = 0; i < 16; i++)
            if (beats[i] !== {(i % 8 == 7), prt_byte((i < 8) ? 3'd3 : 3'd5, 16'(i % 8))}) bad++;
         checks++;
         if (bad != 0) begin errors++; $display("FAIL b2b_data: got %0d bad beats expected 0", bad); end
      end
      checks++;
      if (inv_cnt != 2 || inv_slot_seen !== 3'd5) begin
         errors++; $display("FAIL b2b_inv: got cnt %0d slot %0d expected cnt 2 slot 5", inv_cnt, inv_slot_seen);
      end
      checks++;
      if (bus.frames_sent !== 16'd2) begin errors++; $display("FAIL b2b_frames: got %0d expected 2", bus.frames_sent); end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.slot_valid = 1'b0;
      bus.slot_id    = '0;
      bus.slot_len   = '0;
      bus.abort      = 1'b0;
      bus.tx_ready   = 1'b0;
      bus.rd_data    = '0;
      clear_mon();
      test_reset();
      test_single_byte();
      test_stream64();
      test_backpressure();
      test_bad_len();
      test_abort();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
